ex_mem_stage: RTL

- EX/MEM pipeline boundary directly downstream of the EX-stage ALU.
- Captures ALU result, ALU flag, store data and write-back/memory controls into a two-entry skid buffer with a valid/ready handshake toward MEM.
- Holds the architectural flag register and resolves BRFL (branch-on-flag) as a registered one-cycle pulse to fetch.
- Records a sticky exception indication.

---
 rtl/musa_pkg.sv | 28 ++
 rtl/skid_buffer.sv | 77 +++++++
 rtl/ex_mem_stage.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/musa_pkg.sv
// Shared MUSA definitions: flag codes, datapath widths and the EX/MEM payload bundle.
package musa_pkg;

    localparam int MUSA_DATA_W = 32;
    localparam int MUSA_REG_AW = 5;
    localparam int MUSA_FLAG_W = 3;

    typedef enum logic [MUSA_FLAG_W-1:0] {
        FLAG_NOT_ACTIVED = 3'd0,
        FLAG_EQUAL       = 3'd1,
        FLAG_EXCEPTION   = 3'd2,
        FLAG_OVERFLOW    = 3'd3,
        FLAG_UNDERFLOW   = 3'd4,
        FLAG_ABOVE       = 3'd5
    } flag_code_e;

    typedef struct packed {
        logic [MUSA_DATA_W-1:0] result;
        logic [MUSA_DATA_W-1:0] store_data;
        logic [MUSA_REG_AW-1:0] rd_addr;
        logic                   reg_write;
        logic                   mem_read;
        logic                   mem_write;
    } ex_mem_payload_t;

    localparam int PAYLOAD_W = $bits(ex_mem_payload_t);

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer: main entry drives the output, skid entry absorbs
// one beat of backpressure so in_ready can be a registered signal.
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_ready_q, in_ready_d;
    logic             accept;
    logic             deliver;

    always_comb begin
        accept       = in_valid & in_ready_q;
        deliver      = main_valid_q & out_ready;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (deliver) begin
            // A full buffer never accepts, so skid promotion and refill are exclusive.
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_data_d = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (main_valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end else begin
                main_valid_d = 1'b1;
                main_data_d  = in_data;
            end
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM boundary: payload skid buffer, architectural flag register, BRFL resolution and
// sticky exception. Define EX_MEM_PERF_CNT_EN to add the stall_cnt output.
module ex_mem_stage
    import musa_pkg::*;
#(
    parameter int DATA_W = MUSA_DATA_W,
    parameter int REG_AW = MUSA_REG_AW,
    parameter int FLAG_W = MUSA_FLAG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [FLAG_W-1:0] alu_flag,
    input  logic              flag_we,
    input  logic [DATA_W-1:0] store_data,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              reg_write,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              is_brfl,
    input  logic [FLAG_W-1:0] brfl_cond,
    input  logic [DATA_W-1:0] brfl_target,
    input  logic              flush,
    input  logic              exc_clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_store_data,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic [FLAG_W-1:0] flag_q,
    output logic              branch_taken,
    output logic [DATA_W-1:0] branch_target,
    output logic              exc_pending
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    ex_mem_payload_t   in_payload;
    ex_mem_payload_t   out_payload;
    logic              beat_commit;
    logic [FLAG_W-1:0] flag_d;
    logic              branch_taken_q, branch_taken_d;
    logic [DATA_W-1:0] branch_target_q, branch_target_d;
    logic              exc_pending_q, exc_pending_d;

    always_comb begin
        in_payload.result     = alu_result;
        in_payload.store_data = store_data;
        in_payload.rd_addr    = rd_addr;
        in_payload.reg_write  = reg_write;
        in_payload.mem_read   = mem_read;
        in_payload.mem_write  = mem_write;
    end

    skid_buffer #(
        .WIDTH(PAYLOAD_W)
    ) u_skid_buffer (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_payload),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_payload)
    );

    assign out_result     = out_payload.result;
    assign out_store_data = out_payload.store_data;
    assign out_rd_addr    = out_payload.rd_addr;
    assign out_reg_write  = out_payload.reg_write;
    assign out_mem_read   = out_payload.mem_read;
    assign out_mem_write  = out_payload.mem_write;

    // A beat handshaken during a flush is swallowed with no architectural side effects.
    always_comb begin
        beat_commit     = in_valid & in_ready & !flush;
        flag_d          = flag_q;
        branch_taken_d  = 1'b0;
        branch_target_d = branch_target_q;
        exc_pending_d   = exc_pending_q;
        if (beat_commit && flag_we) begin
            flag_d = alu_flag;
        end
        if (beat_commit && is_brfl && (flag_q == brfl_cond)) begin
            branch_taken_d  = 1'b1;
            branch_target_d = brfl_target;
        end
        if (beat_commit && (alu_flag == FLAG_EXCEPTION)) begin
            exc_pending_d = 1'b1;
        end else if (exc_clear) begin
            exc_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            flag_q          <= FLAG_NOT_ACTIVED;
            branch_taken_q  <= 1'b0;
            branch_target_q <= '0;
            exc_pending_q   <= 1'b0;
        end else begin
            flag_q          <= flag_d;
            branch_taken_q  <= branch_taken_d;
            branch_target_q <= branch_target_d;
            exc_pending_q   <= exc_pending_d;
        end
    end

    assign branch_taken  = branch_taken_q;
    assign branch_target = branch_target_q;
    assign exc_pending   = exc_pending_q;

`ifdef EX_MEM_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
